// File: rtl/game_controller_nxn_pkg.sv
// Shared types for the N x N turn sequencer: cell marks, winner codes and FSM states.
package game_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    X     = 2'b10,
    O     = 2'b11
  } cellState_t;

  typedef enum logic [1:0] {
    W_NONE = 2'b00,
    W_DRAW = 2'b01,
    W_X    = 2'b10,
    W_O    = 2'b11
  } winner_t;

  typedef enum logic [2:0] {
    START,
    PLAYER1,
    PLAYER2,
    WRITE,
    CHECK,
    END
  } statetype;

  // Player 0 plays X, player 1 plays O.
  function automatic logic [1:0] markOf(input logic player);
    return player ? O : X;
  endfunction

endpackage

// File: rtl/game_controller_nxn_if.sv
// Move-request and board-memory bus between the controller (slave) and its environment (master).
interface game_controller_nxn_if #(
  parameter int BOARD_N = 3
) ();
  localparam int CELLS = BOARD_N * BOARD_N;
  localparam int AW    = $clog2(CELLS + 1);

  logic                 playerWrite;
  logic [AW-1:0]        playerInput;
  logic                 moveRejected;
  logic [2*CELLS-1:0]   gBoard;
  logic [AW-1:0]        addr;
  logic [1:0]           cellState;

  modport master (
    output playerWrite, playerInput, gBoard,
    input  moveRejected, addr, cellState
  );

  modport slave (
    input  playerWrite, playerInput, gBoard,
    output moveRejected, addr, cellState
  );

endinterface

// File: rtl/game_controller_nxn_win.sv
// Combinational K-in-a-row detector: flags any horizontal, vertical or diagonal run of equal marks.
module win_check_nxn
  import game_pkg::*;
#(
  parameter int BOARD_N = 3,
  parameter int WIN_LEN = 3
) (
  input  logic [2*BOARD_N*BOARD_N-1:0] gBoard,
  output logic                         win,
  output logic [1:0]                   mark
);
  localparam int CELLS = BOARD_N * BOARD_N;

  logic [CELLS-1:0] cellHit;
  logic [1:0]       markAcc [CELLS+1];

  assign markAcc[0] = 2'b00;

  for (genvar gi = 0; gi < CELLS; gi++) begin : g_start
    localparam int R = gi / BOARD_N;
    localparam int C = gi % BOARD_N;
    logic [3:0] dirHit;

    // Directions: 0 row, 1 column, 2 diagonal, 3 anti-diagonal; each run starts at cell gi.
    for (genvar gd = 0; gd < 4; gd++) begin : g_dir
      localparam int DR   = (gd == 0) ? 0 : 1;
      localparam int DC   = (gd == 1) ? 0 : ((gd == 3) ? -1 : 1);
      localparam int STEP = DR * BOARD_N + DC;
      localparam int ER   = R + DR * (WIN_LEN - 1);
      localparam int EC   = C + DC * (WIN_LEN - 1);
      if (ER < BOARD_N && EC >= 0 && EC < BOARD_N) begin : g_fit
        logic [WIN_LEN-1:0] same;
        for (genvar gk = 0; gk < WIN_LEN; gk++) begin : g_k
          assign same[gk] = (gBoard[2*(gi+gk*STEP) +: 2] == gBoard[2*gi +: 2]);
        end
        // Both X and O have the upper bit set, so it doubles as a non-empty test.
        assign dirHit[gd] = gBoard[2*gi+1] & (&same);
      end else begin : g_nofit
        assign dirHit[gd] = 1'b0;
      end
    end

    assign cellHit[gi]    = |dirHit;
    assign markAcc[gi+1]  = markAcc[gi] | (cellHit[gi] ? gBoard[2*gi +: 2] : 2'b00);
  end

  // Only the player who just moved can own a line, so OR-merging the hit marks is exact.
  assign win  = |cellHit;
  assign mark = markAcc[CELLS];

endmodule

// File: rtl/game_controller_nxn.sv
// Turn sequencer for an N x N, K-in-a-row game. Define TURN_TIMEOUT_EN to add a per-turn forfeit timer.
module game_controller_nxn
  import game_pkg::*;
#(
  parameter int BOARD_N        = 3,
  parameter int WIN_LEN        = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  ph1,
  input  logic                  reset,
  input  logic                  isPlayer1Start,
  input  logic                  newGame,
  game_controller_nxn_if.slave  bus,
  output logic                  gameIsDone,
  output logic [1:0]            winner,
  output logic                  turn,
  output logic                  timedOut
);
  localparam int            CELLS     = BOARD_N * BOARD_N;
  localparam int            AW        = $clog2(CELLS + 1);
  localparam int            MAPW      = 1 << AW;
  localparam logic [AW-1:0] IDLE_ADDR = '1;

  statetype      stateReg, stateNext;
  logic [AW-1:0] idxReg, idxNext;
  logic [AW-1:0] moveCountReg, moveCountNext;
  logic [1:0]    winnerReg, winnerNext;
  logic [AW-1:0] addrReg, addrNext;
  logic [1:0]    cellStateReg, cellStateNext;
  logic          rejectReg, rejectNext;
  logic          turnReg, turnNext;
  logic          doneReg, doneNext;
  logic          timedOutReg, timedOutNext;
  logic          timeUp;
  logic          winHit;
  logic [1:0]    winMark;

  // Legality map padded to 2**AW entries so out-of-range indices read as occupied.
  logic [MAPW-1:0] emptyMap;
  for (genvar gi = 0; gi < MAPW; gi++) begin : g_empty
    if (gi < CELLS) begin : g_cell
      assign emptyMap[gi] = (bus.gBoard[2*gi +: 2] == EMPTY);
    end else begin : g_pad
      assign emptyMap[gi] = 1'b0;
    end
  end

  win_check_nxn #(
    .BOARD_N (BOARD_N),
    .WIN_LEN (WIN_LEN)
  ) u_win (
    .gBoard (bus.gBoard),
    .win    (winHit),
    .mark   (winMark)
  );

`ifdef TURN_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] timerReg, timerNext;

  assign timeUp = (timerReg == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    timerNext = timerReg;
    if ((stateNext == PLAYER1 || stateNext == PLAYER2) && stateNext != stateReg)
      timerNext = '0;
    else if (stateReg == PLAYER1 || stateReg == PLAYER2)
      timerNext = timerReg + 1'b1;
  end

  always_ff @(posedge ph1) begin
    if (!reset) timerReg <= '0;
    else        timerReg <= timerNext;
  end
`else
  assign timeUp = 1'b0;
`endif

  always_comb begin
    stateNext     = stateReg;
    idxNext       = idxReg;
    moveCountNext = moveCountReg;
    winnerNext    = winnerReg;
    turnNext      = turnReg;
    rejectNext    = 1'b0;
    timedOutNext  = timedOutReg;

    case (stateReg)
      START: begin
        moveCountNext = '0;
        winnerNext    = W_NONE;
        timedOutNext  = 1'b0;
        stateNext     = isPlayer1Start ? PLAYER1 : PLAYER2;
      end
      PLAYER1, PLAYER2: begin
        // A legal move on the expiry edge still counts; the forfeit only applies otherwise.
        if (bus.playerWrite && emptyMap[bus.playerInput]) begin
          idxNext   = bus.playerInput;
          stateNext = WRITE;
        end else if (timeUp) begin
          winnerNext   = (stateReg == PLAYER2) ? W_X : W_O;
          timedOutNext = 1'b1;
          stateNext    = END;
        end else if (bus.playerWrite) begin
          rejectNext = 1'b1;
        end
      end
      WRITE: begin
        moveCountNext = moveCountReg + 1'b1;
        stateNext     = CHECK;
      end
      CHECK: begin
        if (winHit) begin
          winnerNext = winMark;
          stateNext  = END;
        end else if (moveCountReg == AW'(CELLS)) begin
          winnerNext = W_DRAW;
          stateNext  = END;
        end else begin
          stateNext = turnReg ? PLAYER1 : PLAYER2;
        end
      end
      END: begin
        if (newGame) stateNext = START;
      end
      default: stateNext = START;
    endcase

    if (stateNext == PLAYER1) turnNext = 1'b0;
    if (stateNext == PLAYER2) turnNext = 1'b1;

    // Outputs are computed from the next state so the registered copies line up with it.
    addrNext      = (stateNext == WRITE) ? idxNext : IDLE_ADDR;
    cellStateNext = (stateNext == WRITE) ? markOf(turnReg) : EMPTY;
    doneNext      = (stateNext == END);
  end

  always_ff @(posedge ph1) begin
    if (!reset) begin
      stateReg     <= START;
      idxReg       <= '0;
      moveCountReg <= '0;
      winnerReg    <= W_NONE;
      addrReg      <= IDLE_ADDR;
      cellStateReg <= EMPTY;
      rejectReg    <= 1'b0;
      turnReg      <= 1'b0;
      doneReg      <= 1'b0;
      timedOutReg  <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      idxReg       <= idxNext;
      moveCountReg <= moveCountNext;
      winnerReg    <= winnerNext;
      addrReg      <= addrNext;
      cellStateReg <= cellStateNext;
      rejectReg    <= rejectNext;
      turnReg      <= turnNext;
      doneReg      <= doneNext;
      timedOutReg  <= timedOutNext;
    end
  end

  assign bus.addr         = addrReg;
  assign bus.cellState    = cellStateReg;
  assign bus.moveRejected = rejectReg;
  assign gameIsDone       = doneReg;
  assign winner           = winnerReg;
  assign turn             = turnReg;
  assign timedOut         = timedOutReg;

endmodule

// File: tb/tb_game_controller_nxn.sv
// Directed bench for the 3x3 controller with a behavioural board memory; timeout steps need TURN_TIMEOUT_EN.
module tb_game_controller_nxn;
  import game_pkg::*;

  localparam int              BOARD_N        = 3;
  localparam int              WIN_LEN        = 3;
  localparam int              TIMEOUT_CYCLES = 16;
  localparam int              CELLS          = BOARD_N * BOARD_N;
  localparam logic [3:0]      IDLE           = 4'hF;

  logic       ph1 = 1'b0;
  logic       reset = 1'b0;
  logic       isPlayer1Start = 1'b1;
  logic       newGame = 1'b0;
  logic       clr = 1'b1;
  logic       gameIsDone, turn, timedOut;
  logic [1:0] winner;
  logic [1:0] mem [0:15];
  int         compared = 0;
  int         mismatched = 0;
  int         drawSeq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

  game_controller_nxn_if #(.BOARD_N(BOARD_N)) bus ();

  game_controller_nxn #(
    .BOARD_N        (BOARD_N),
    .WIN_LEN        (WIN_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .ph1            (ph1),
    .reset          (reset),
    .isPlayer1Start (isPlayer1Start),
    .newGame        (newGame),
    .bus            (bus),
    .gameIsDone     (gameIsDone),
    .winner         (winner),
    .turn           (turn),
    .timedOut       (timedOut)
  );

  always #5 ph1 = ~ph1;

  // Board memory: captures each write at the end of the WRITE cycle.
  for (genvar gi = 0; gi < CELLS; gi++) begin : g_board
    assign bus.gBoard[2*gi +: 2] = mem[gi];
  end

  always @(posedge ph1) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) mem[i[3:0]] <= 2'b00;
    end else if (bus.addr != IDLE) begin
      mem[bus.addr] <= bus.cellState;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  task automatic doMove(input int idx, input logic [1:0] mark, input logic nextTurn,
                        input logic [1:0] expWinner, input logic expDone);
    bus.playerWrite = 1'b1;
    bus.playerInput = 4'(idx);
    tick();
    bus.playerWrite = 1'b0;
    chk($sformatf("write_addr_%0d", idx), 32'(bus.addr), 32'(idx));
    chk($sformatf("write_mark_%0d", idx), 32'(bus.cellState), 32'(mark));
    tick();
    chk($sformatf("check_addr_idle_%0d", idx), 32'(bus.addr), 32'(IDLE));
    tick();
    chk($sformatf("done_after_%0d", idx), 32'(gameIsDone), 32'(expDone));
    chk($sformatf("winner_after_%0d", idx), 32'(winner), 32'(expWinner));
    if (!expDone) chk($sformatf("turn_after_%0d", idx), 32'(turn), 32'(nextTurn));
    $display("move cell=%0d mark=%b -> turn=%0d winner=%b done=%0d", idx, mark, turn, winner, gameIsDone);
  endtask

  task automatic reject(input int idx, input logic expTurn);
    bus.playerWrite = 1'b1;
    bus.playerInput = 4'(idx);
    tick();
    bus.playerWrite = 1'b0;
    chk($sformatf("reject_pulse_%0d", idx), 32'(bus.moveRejected), 32'd1);
    chk($sformatf("reject_nowrite_%0d", idx), 32'(bus.addr), 32'(IDLE));
    chk($sformatf("reject_turn_%0d", idx), 32'(turn), 32'(expTurn));
    tick();
    chk($sformatf("reject_end_%0d", idx), 32'(bus.moveRejected), 32'd0);
    $display("reject cell=%0d turn=%0d", idx, turn);
  endtask

  initial begin
    bus.playerWrite = 1'b0;
    bus.playerInput = '0;

    // Reset state
    tick();
    tick();
    chk("rst_addr", 32'(bus.addr), 32'(IDLE));
    chk("rst_cellState", 32'(bus.cellState), 32'd0);
    chk("rst_done", 32'(gameIsDone), 32'd0);
    chk("rst_winner", 32'(winner), 32'd0);
    chk("rst_turn", 32'(turn), 32'd0);
    chk("rst_reject", 32'(bus.moveRejected), 32'd0);
    chk("rst_timedOut", 32'(timedOut), 32'd0);
    $display("reset released, isPlayer1Start=1");

    // Illegal request held through START: ignored there, rejected one cycle later in PLAYER1.
    reset = 1'b1;
    clr = 1'b0;
    bus.playerWrite = 1'b1;
    bus.playerInput = 4'd9;
    tick();
    chk("start_ignores_write", 32'(bus.moveRejected), 32'd0);
    chk("start_turn", 32'(turn), 32'd0);
    chk("start_winner", 32'(winner), 32'd0);
    tick();
    bus.playerWrite = 1'b0;
    chk("player1_after_one_start", 32'(bus.moveRejected), 32'd1);
    tick();
    chk("player1_reject_clears", 32'(bus.moveRejected), 32'd0);

    // Game 1: X wins on the top row
    doMove(0, 2'b10, 1'b1, 2'b00, 1'b0);
    reject(0, 1'b1);
    reject(9, 1'b1);
    doMove(4, 2'b11, 1'b0, 2'b00, 1'b0);
    doMove(1, 2'b10, 1'b1, 2'b00, 1'b0);
    doMove(5, 2'b11, 1'b0, 2'b00, 1'b0);
    doMove(2, 2'b10, 1'b0, 2'b10, 1'b1);

    bus.playerWrite = 1'b1;
    bus.playerInput = 4'd3;
    tick();
    bus.playerWrite = 1'b0;
    chk("end_ignores_reject", 32'(bus.moveRejected), 32'd0);
    chk("end_ignores_write", 32'(bus.addr), 32'(IDLE));
    chk("end_holds_winner", 32'(winner), 32'(2'b10));
    chk("end_no_timeout", 32'(timedOut), 32'd0);

    newGame = 1'b1;
    clr = 1'b1;
    tick();
    newGame = 1'b0;
    chk("newgame_done_low", 32'(gameIsDone), 32'd0);
    tick();
    clr = 1'b0;
    chk("newgame_winner_cleared", 32'(winner), 32'd0);
    chk("newgame_turn", 32'(turn), 32'd0);
    $display("new game started");

    // Game 2: nine moves, no line
    for (int i = 0; i < 8; i++) begin
      doMove(drawSeq[i], (i % 2 == 0) ? 2'b10 : 2'b11, (i % 2 == 0) ? 1'b1 : 1'b0, 2'b00, 1'b0);
    end
    doMove(drawSeq[8], 2'b10, 1'b0, 2'b01, 1'b1);

    // Reset asserted during WRITE, player 2 starting
    reset = 1'b0;
    clr = 1'b1;
    isPlayer1Start = 1'b0;
    tick();
    reset = 1'b1;
    clr = 1'b0;
    tick();
    chk("p2start_turn", 32'(turn), 32'd1);
    chk("p2start_done", 32'(gameIsDone), 32'd0);
    chk("p2start_winner", 32'(winner), 32'd0);
    bus.playerWrite = 1'b1;
    bus.playerInput = 4'd4;
    tick();
    bus.playerWrite = 1'b0;
    chk("midwrite_addr", 32'(bus.addr), 32'd4);
    chk("midwrite_mark", 32'(bus.cellState), 32'(2'b11));
    reset = 1'b0;
    tick();
    chk("reset_drops_addr", 32'(bus.addr), 32'(IDLE));
    chk("reset_drops_mark", 32'(bus.cellState), 32'd0);
    chk("reset_clears_turn", 32'(turn), 32'd0);
    reset = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("restart_turn_p2", 32'(turn), 32'd1);
    $display("reset during WRITE recovered to player 2");
    reject(9, 1'b1);

`ifdef TURN_TIMEOUT_EN
    // Player 1 idles until the turn budget runs out
    reset = 1'b0;
    isPlayer1Start = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) tick();
    chk("timeout_not_yet", 32'(gameIsDone), 32'd0);
    tick();
    chk("timeout_done", 32'(gameIsDone), 32'd1);
    chk("timeout_winner", 32'(winner), 32'(2'b11));
    chk("timeout_flag", 32'(timedOut), 32'd1);
    newGame = 1'b1;
    tick();
    newGame = 1'b0;
    tick();
    chk("timeout_cleared", 32'(timedOut), 32'd0);
    $display("timeout forfeit observed");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
